pmbus_poll_scheduler: RTL and testbench

// Sequences PMBus word-read transactions from PL to the ZC702 power rails. Owns the single

---
 rtl/pmbus_poll_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_pmbus_poll_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmbus_poll_scheduler.sv
// pmbus_poll_scheduler: shares one PMBus word-read engine between a periodic
// rail-table sweep and a single host requester, and streams sweep results out
// as telemetry writes.
//
// Handshake semantics (all valid/ready pairs): a transfer happens in a cycle
// where valid and ready are both 1. A source raises valid and holds it, together
// with its payload, until that cycle. host_req_ready and txn_valid never wait on
// the other side's ready/valid within the same cycle in a way that could loop.
module pmbus_poll_scheduler #(
  parameter int                     NUM_RAILS      = 4,
  parameter logic [NUM_RAILS*7-1:0] RAIL_ADDR      = {4{7'h34}},
  parameter logic [NUM_RAILS*8-1:0] RAIL_CODE      = {4{8'h8B}},
  parameter int                     PERIOD_CYCLES  = 1_000_000,
  parameter int                     TIMEOUT_CYCLES = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        host_req_valid,
  output logic        host_req_ready,
  input  logic [6:0]  host_req_addr,
  input  logic [7:0]  host_req_code,
  output logic        host_rsp_valid,
  output logic [15:0] host_rsp_data,
  output logic        host_rsp_err,
  output logic        txn_valid,
  input  logic        txn_ready,
  output logic [6:0]  txn_addr,
  output logic [7:0]  txn_code,
  input  logic        txn_done,
  input  logic [15:0] txn_data,
  input  logic        txn_nack,
  output logic        txn_abort,
  output logic        tlm_valid,
  output logic [3:0]  tlm_idx,
  output logic [15:0] tlm_data,
  output logic        tlm_err,
  output logic        overrun,
  input  logic        overrun_clr,
  output logic        busy
);

  localparam int         PW       = $clog2(PERIOD_CYCLES);
  localparam int         TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [3:0] LAST_IDX = 4'(NUM_RAILS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   period_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            tick;
  logic            sweep_act;   // sweep pending or in progress
  logic [3:0]      idx;
  logic            last_host;   // 1 = most recent grant went to the host
  logic            cur_host;    // source of the transaction in flight
  logic            grant_host, grant_sweep;
  logic            fin, fin_err;
  logic [15:0]     fin_data;

  // Unpack the flat rail tables into 16-entry arrays indexed by idx.
  logic [6:0] rail_addr [16];
  logic [7:0] rail_code [16];
  for (genvar gi = 0; gi < 16; gi++) begin : g_rail
    if (gi < NUM_RAILS) begin : g_used
      assign rail_addr[gi] = RAIL_ADDR[gi*7 +: 7];
      assign rail_code[gi] = RAIL_CODE[gi*8 +: 8];
    end else begin : g_unused
      assign rail_addr[gi] = '0;
      assign rail_code[gi] = '0;
    end
  end

  assign tick = enable && (period_cnt == PW'(PERIOD_CYCLES - 1));
  assign busy = (state_q != S_IDLE);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, arbitration, handshake strobes and transaction completion.
  always_comb begin
    state_d        = state_q;
    grant_host     = 1'b0;
    grant_sweep    = 1'b0;
    host_req_ready = 1'b0;
    txn_valid      = 1'b0;
    txn_abort      = 1'b0;
    fin            = 1'b0;
    fin_err        = 1'b0;
    fin_data       = '0;
    case (state_q)
      S_IDLE: begin
        // With both sources waiting, serve whichever was not served last.
        if (host_req_valid && (!sweep_act || !last_host)) grant_host = 1'b1;
        else if (sweep_act)                                grant_sweep = 1'b1;
        host_req_ready = grant_host && !rst;
        if (grant_host || grant_sweep) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        txn_valid = 1'b1;
        if (txn_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the last allowed cycle still counts as a completion.
        if (txn_done) begin
          fin      = 1'b1;
          fin_err  = txn_nack;
          fin_data = txn_nack ? 16'h0 : txn_data;
          state_d  = S_IDLE;
        end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          txn_abort = 1'b1;
          fin       = 1'b1;
          fin_err   = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Period timer, sweep bookkeeping, latched transaction and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt     <= '0;
      tmo_cnt        <= '0;
      sweep_act      <= 1'b0;
      idx            <= '0;
      last_host      <= 1'b0;
      cur_host       <= 1'b0;
      overrun        <= 1'b0;
      txn_addr       <= '0;
      txn_code       <= '0;
      host_rsp_valid <= 1'b0;
      host_rsp_data  <= '0;
      host_rsp_err   <= 1'b0;
      tlm_valid      <= 1'b0;
      tlm_idx        <= '0;
      tlm_data       <= '0;
      tlm_err        <= 1'b0;
    end else begin
      host_rsp_valid <= 1'b0;
      tlm_valid      <= 1'b0;

      if (!enable || tick) period_cnt <= '0;
      else                 period_cnt <= period_cnt + PW'(1);

      // A tick that lands on a live sweep is dropped and flagged; set beats clear.
      if (tick && sweep_act) overrun <= 1'b1;
      else if (overrun_clr)  overrun <= 1'b0;

      if (grant_host) begin
        cur_host  <= 1'b1;
        last_host <= 1'b1;
        txn_addr  <= host_req_addr;
        txn_code  <= host_req_code;
      end else if (grant_sweep) begin
        cur_host  <= 1'b0;
        last_host <= 1'b0;
        txn_addr  <= rail_addr[idx];
        txn_code  <= rail_code[idx];
      end

      if (state_q == S_ISSUE && txn_ready) tmo_cnt <= '0;
      else if (state_q == S_WAIT)          tmo_cnt <= tmo_cnt + TW'(1);

      if (fin) begin
        if (cur_host) begin
          host_rsp_valid <= 1'b1;
          host_rsp_data  <= fin_data;
          host_rsp_err   <= fin_err;
        end else begin
          tlm_valid <= 1'b1;
          tlm_idx   <= idx;
          tlm_data  <= fin_data;
          tlm_err   <= fin_err;
          if (idx == LAST_IDX) begin
            idx       <= '0;
            sweep_act <= 1'b0;
          end else begin
            idx <= idx + 4'd1;
          end
        end
      end

      if (tick && !sweep_act) begin
        sweep_act <= 1'b1;
        idx       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pmbus_poll_scheduler.sv
// tb_pmbus_poll_scheduler: randomized host traffic and a behavioural PMBus
// engine around pmbus_poll_scheduler, with a queue-based scoreboard.
`timescale 1ns/1ps
module tb_pmbus_poll_scheduler;

  localparam int NR  = 4;
  localparam int PER = 200;
  localparam int TMO = 50;
  localparam int LAT = 10;
  localparam logic [NR*7-1:0] RA = {7'h33, 7'h32, 7'h31, 7'h30};
  localparam logic [NR*8-1:0] RC = {8'h8D, 8'h8C, 8'h8B, 8'h88};
  localparam logic [6:0] NACK_HOST = 7'h5A;

  logic [6:0] rail_a [NR] = '{7'h30, 7'h31, 7'h32, 7'h33};
  logic [7:0] rail_c [NR] = '{8'h88, 8'h8B, 8'h8C, 8'h8D};

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        host_req_valid, host_req_ready;
  logic [6:0]  host_req_addr;
  logic [7:0]  host_req_code;
  logic        host_rsp_valid, host_rsp_err;
  logic [15:0] host_rsp_data;
  logic        txn_valid, txn_ready, txn_done, txn_nack, txn_abort;
  logic [6:0]  txn_addr;
  logic [7:0]  txn_code;
  logic [15:0] txn_data;
  logic        tlm_valid, tlm_err, overrun, overrun_clr, busy;
  logic [3:0]  tlm_idx;
  logic [15:0] tlm_data;

  pmbus_poll_scheduler #(
    .NUM_RAILS(NR), .RAIL_ADDR(RA), .RAIL_CODE(RC),
    .PERIOD_CYCLES(PER), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_req_addr(host_req_addr), .host_req_code(host_req_code),
    .host_rsp_valid(host_rsp_valid), .host_rsp_data(host_rsp_data), .host_rsp_err(host_rsp_err),
    .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_addr(txn_addr), .txn_code(txn_code),
    .txn_done(txn_done), .txn_data(txn_data), .txn_nack(txn_nack), .txn_abort(txn_abort),
    .tlm_valid(tlm_valid), .tlm_idx(tlm_idx), .tlm_data(tlm_data), .tlm_err(tlm_err),
    .overrun(overrun), .overrun_clr(overrun_clr), .busy(busy)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  bit mute_mode = 1'b0;            // engine never answers
  logic [20:0] exp_tlm[$];         // {idx, err, data}
  logic [16:0] exp_host[$];        // {err, data}
  logic [6:0]  txn_log[$];         // addresses in grant order

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] eng_word(input logic [6:0] a, input logic [7:0] c);
    return {a, c, 1'b1};
  endfunction

  function automatic bit is_nack(input logic [6:0] a);
    return (a == rail_a[2]) || (a == NACK_HOST);
  endfunction

  // Reference result of one word read: error -> data 0.
  function automatic logic [16:0] expect_rsp(input logic [6:0] a, input logic [7:0] c);
    if (mute_mode || is_nack(a)) return {1'b1, 16'h0};
    return {1'b0, eng_word(a, c)};
  endfunction

  function automatic logic [63:0] outs();
    return {4'h0, host_req_ready, host_rsp_valid, host_rsp_data, host_rsp_err,
            txn_valid, txn_addr, txn_code, txn_abort,
            tlm_valid, tlm_idx, tlm_data, tlm_err, overrun, busy};
  endfunction

  // ---------------- reference model: period ticks, sweeps, overrun ----------------
  // A sweep is considered live while any of its telemetry writes is still owed.
  int pc = 0;
  bit ov_m = 1'b0;
  bit tk_m, set_m;
  logic [16:0] r_m;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pc = 0;
      ov_m = 1'b0;
      exp_tlm.delete();
      exp_host.delete();
    end else begin
      tk_m = enable && (pc == PER - 1);
      if (!enable || tk_m) pc = 0;
      else pc++;
      set_m = tk_m && (exp_tlm.size() != 0);
      if (tk_m && !set_m)
        for (int i = 0; i < NR; i++) begin
          r_m = expect_rsp(rail_a[i], rail_c[i]);
          exp_tlm.push_back({4'(i), r_m});
        end
      if (set_m) ov_m = 1'b1;
      else if (overrun_clr) ov_m = 1'b0;
    end
  end

  // ---------------- behavioural engine ----------------
  logic [6:0] eng_a;
  logic [7:0] eng_c;
  int acc_cyc, wk;
  initial begin
    txn_ready = 1'b0; txn_done = 1'b0; txn_data = '0; txn_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && txn_valid) begin
        eng_a = txn_addr;
        eng_c = txn_code;
        txn_log.push_back(eng_a);
        txn_ready = 1'b1;
        acc_cyc = cyc;
        @(negedge clk);
        txn_ready = 1'b0;
        if (!rst) begin
          if (mute_mode) begin
            wk = 0;
            while (!rst && !txn_abort && wk < TMO + 20) begin @(negedge clk); wk++; end
            if (!rst) check("abort_latency", 64'(cyc - acc_cyc), 64'(TMO));
          end else begin
            for (int k = 1; k < LAT && !rst; k++) @(negedge clk);
            if (!rst) begin
              txn_nack = is_nack(eng_a);
              txn_data = txn_nack ? 16'($urandom) : eng_word(eng_a, eng_c);
              txn_done = 1'b1;
              @(negedge clk);
              txn_done = 1'b0;
              txn_nack = 1'b0;
            end
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [20:0] e_t;
  logic [16:0] e_h;
  always @(negedge clk) begin
    if (!rst) begin
      if (tlm_valid) begin
        if (exp_tlm.size() == 0) check("tlm_unexpected", 64'(tlm_valid), 64'(0));
        else begin
          e_t = exp_tlm.pop_front();
          check("tlm_write", 64'({tlm_idx, tlm_err, tlm_data}), 64'(e_t));
        end
      end
      if (host_rsp_valid) begin
        if (exp_host.size() == 0) check("host_unexpected", 64'(host_rsp_valid), 64'(0));
        else begin
          e_h = exp_host.pop_front();
          check("host_rsp", 64'({host_rsp_err, host_rsp_data}), 64'(e_h));
        end
      end
      check("overrun", 64'(overrun), 64'(ov_m));
      if (!mute_mode) check("abort_quiet", 64'(txn_abort), 64'(0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic host_one(input logic [6:0] a, input logic [7:0] c);
    int w;
    host_req_addr  = a;
    host_req_code  = c;
    host_req_valid = 1'b1;
    exp_host.push_back(expect_rsp(a, c));
    w = 0;
    @(negedge clk);
    while (!host_req_ready && w < 3000) begin @(negedge clk); w++; end
    check("host_accept", 64'(host_req_ready), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_tlm.size() != 0 || exp_host.size() != 0 || busy) && w < 3000) begin
      @(posedge clk); #1; w++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain", 64'(exp_tlm.size() + exp_host.size()), 64'(0));
  endtask

  task automatic wait_tick_next();
    int w;
    w = 0;
    @(posedge clk); #1;
    while (pc != PER - 1 && w < 2 * PER) begin @(posedge clk); #1; w++; end
  endtask

  task automatic pulse_clr();
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int burst_end, found, w, n0;
  initial begin
    rst = 1'b1; enable = 1'b0; overrun_clr = 1'b0;
    host_req_valid = 1'b0; host_req_addr = '0; host_req_code = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 64'(0));
    @(posedge clk); #1 rst = 1'b0;

    // Normal sweeps plus isolated host reads, one of them NACKed.
    enable = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    host_one(NACK_HOST, 8'h8B);
    host_req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    host_one(7'h50 + 7'($urandom_range(0, 9)), 8'($urandom));
    host_req_valid = 1'b0;
    repeat (3 * PER) @(posedge clk);
    #1;

    // Host held valid throughout: grants must alternate with the sweep.
    txn_log.delete();
    for (int i = 0; i < 40; i++) host_one(7'h50 + 7'($urandom_range(0, 15)), 8'($urandom));
    burst_end = txn_log.size();
    host_req_valid = 1'b0;
    found = -1;
    for (int i = 1; i + 6 < burst_end; i++)
      if (found < 0 && txn_log[i] == rail_a[0]) found = i;
    check("sweep_in_burst", 64'(found >= 1), 64'(1));
    if (found >= 1) begin
      check("alt_pre_host", 64'(txn_log[found-1][6:4]), 64'(3'h5));
      for (int m = 0; m < 7; m++) begin
        if (m % 2 == 0) check("alt_rail", 64'(txn_log[found+m]), 64'(rail_a[m/2]));
        else            check("alt_host", 64'(txn_log[found+m][6:4]), 64'(3'h5));
      end
    end

    // Silent engine: every entry times out, sweeps outgrow the period.
    enable = 1'b0;
    drain();
    mute_mode = 1'b1;
    enable = 1'b1;
    w = 0;
    while (!ov_m && w < 4 * PER) begin @(posedge clk); #1; w++; end
    check("overrun_set", 64'(overrun), 64'(1));
    repeat (20) @(posedge clk);
    #1;
    pulse_clr();
    check("overrun_clr_alone", 64'(overrun), 64'(0));
    for (int k = 0; k < 2; k++) begin
      wait_tick_next();
      pulse_clr();
    end
    check("overrun_set_wins", 64'(overrun), 64'(1));
    enable = 1'b0;
    drain();
    mute_mode = 1'b0;
    pulse_clr();
    check("overrun_cleared", 64'(overrun), 64'(0));

    // Asynchronous reset while a transaction is waiting on the engine.
    enable = 1'b1;
    n0 = txn_log.size();
    w = 0;
    while (txn_log.size() == n0 && w < 3 * PER) begin @(negedge clk); w++; end
    repeat (3) @(negedge clk);
    check("busy_before_reset", 64'(busy), 64'(1));
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", outs(), 64'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (PER + 120) @(posedge clk);
    #1;

    enable = 1'b0;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
